oled_screen_sequencer: RTL

OLED_SCREEN_SEQUENCER -- requirements
Module: oled_screen_sequencer

---
 rtl/oled_screen_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/oled_screen_sequencer.sv
// oled_screen_sequencer
// Cycles through NUM_SCREENS pages of ROWS x COLS characters on a character OLED.
// Powers the display on, copies every character of the current screen from a text
// source into the display driver, triggers a display update, then holds the screen
// for DWELL_MS milliseconds (or until next) before moving to the following screen.
// Dropping enable finishes any outstanding handshake and powers the display off.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   enable                         run the sequence while high
//   next                           one-cycle pulse, ends the current dwell early
//   char_screen/char_row/char_col  text-source address
//   char_data                      text-source ASCII, valid one clk after the address
//   write_start/write_ready        character-write handshake
//   write_ascii_data/write_base_addr  character-write payload
//   update_start/update_clear/update_ready  display-update handshake
//   disp_on_start/disp_on_ready    power-on handshake
//   disp_off_start/disp_off_ready  power-off handshake
//   cur_screen                     screen currently shown
//   busy                           high whenever the sequencer is not idle
module oled_screen_sequencer #(
    parameter int unsigned NUM_SCREENS = 2,
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 16,
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned DWELL_MS    = 4000,
    parameter int unsigned LOOP        = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       next,
    output logic [3:0] char_screen,
    output logic [1:0] char_row,
    output logic [3:0] char_col,
    input  logic [7:0] char_data,
    output logic       write_start,
    input  logic       write_ready,
    output logic [7:0] write_ascii_data,
    output logic [8:0] write_base_addr,
    output logic       update_start,
    output logic       update_clear,
    input  logic       update_ready,
    output logic       disp_on_start,
    input  logic       disp_on_ready,
    output logic       disp_off_start,
    input  logic       disp_off_ready,
    output logic [3:0] cur_screen,
    output logic       busy
);

    localparam int unsigned PrescDiv   = CLK_FREQ_HZ / 1000;
    localparam int unsigned PrescW     = (PrescDiv > 1) ? $clog2(PrescDiv) : 1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(PrescDiv - 1);
    localparam logic [11:0]       MsLast    = 12'(DWELL_MS - 1);
    localparam logic [1:0]        RowLast   = 2'(ROWS - 1);
    localparam logic [3:0]        ColLast   = 4'(COLS - 1);
    localparam logic [3:0]        ScrLast   = 4'(NUM_SCREENS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StPwrOn,
        StPwrOnWait,
        StFetch,
        StWrite,
        StWriteWait,
        StUpdate,
        StUpdateWait,
        StDwell,
        StHold,
        StPwrOff,
        StPwrOffWait
    } state_t;

    state_t            state;
    logic [PrescW-1:0] presc;
    logic [11:0]       ms_cnt;

    assign busy = (state != StIdle);

    // char_row/char_col double as the position counters of the screen being drawn.
    // Start pulses are registered: a pulse is launched from a cycle where ready was
    // high and is visible in the first cycle of the matching *_WAIT state. The WAIT
    // states only leave once the pulse has dropped and ready is high again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= StIdle;
            presc            <= '0;
            ms_cnt           <= '0;
            char_screen      <= '0;
            char_row         <= '0;
            char_col         <= '0;
            write_start      <= 1'b0;
            write_ascii_data <= '0;
            write_base_addr  <= '0;
            update_start     <= 1'b0;
            update_clear     <= 1'b0;
            disp_on_start    <= 1'b0;
            disp_off_start   <= 1'b0;
            cur_screen       <= '0;
        end else begin
            write_start    <= 1'b0;
            update_start   <= 1'b0;
            disp_on_start  <= 1'b0;
            disp_off_start <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (enable) begin
                        state <= StPwrOn;
                    end
                end

                StPwrOn: begin
                    if (disp_on_ready) begin
                        disp_on_start <= 1'b1;
                        state         <= StPwrOnWait;
                    end
                end

                StPwrOnWait: begin
                    if (disp_on_ready && !disp_on_start) begin
                        char_screen <= cur_screen;
                        char_row    <= '0;
                        char_col    <= '0;
                        state       <= StFetch;
                    end
                end

                // Address is on char_* during this cycle; data arrives next cycle.
                StFetch: begin
                    state <= StWrite;
                end

                StWrite: begin
                    write_ascii_data <= char_data;
                    write_base_addr  <= {char_row, char_col, 3'b000};
                    if (write_ready) begin
                        write_start <= 1'b1;
                        state       <= StWriteWait;
                    end
                end

                StWriteWait: begin
                    if (write_ready && !write_start) begin
                        if (!enable) begin
                            state <= StPwrOff;
                        end else if (char_row == RowLast && char_col == ColLast) begin
                            state <= StUpdate;
                        end else begin
                            if (char_col == ColLast) begin
                                char_col <= '0;
                                char_row <= char_row + 2'd1;
                            end else begin
                                char_col <= char_col + 4'd1;
                            end
                            state <= StFetch;
                        end
                    end
                end

                StUpdate: begin
                    if (update_ready) begin
                        update_start <= 1'b1;
                        update_clear <= 1'b0;
                        state        <= StUpdateWait;
                    end
                end

                StUpdateWait: begin
                    if (update_ready && !update_start) begin
                        if (!enable) begin
                            state <= StPwrOff;
                        end else begin
                            presc  <= '0;
                            ms_cnt <= '0;
                            state  <= StDwell;
                        end
                    end
                end

                StDwell: begin
                    if (!enable) begin
                        state <= StPwrOff;
                    end else if (next || (presc == PrescLast && ms_cnt == MsLast)) begin
                        if (cur_screen < ScrLast) begin
                            cur_screen  <= cur_screen + 4'd1;
                            char_screen <= cur_screen + 4'd1;
                            char_row    <= '0;
                            char_col    <= '0;
                            state       <= StFetch;
                        end else if (LOOP != 0) begin
                            cur_screen  <= '0;
                            char_screen <= '0;
                            char_row    <= '0;
                            char_col    <= '0;
                            state       <= StFetch;
                        end else begin
                            state <= StHold;
                        end
                    end else if (presc == PrescLast) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt + 12'd1;
                    end else begin
                        presc <= presc + PrescW'(1);
                    end
                end

                StHold: begin
                    if (!enable) begin
                        state <= StPwrOff;
                    end
                end

                StPwrOff: begin
                    if (disp_off_ready) begin
                        disp_off_start <= 1'b1;
                        state          <= StPwrOffWait;
                    end
                end

                StPwrOffWait: begin
                    if (disp_off_ready && !disp_off_start) begin
                        cur_screen <= '0;
                        state      <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
